regfile_mp: RTL

//  Parametrised multi-port integer register file for the pipelined CPU datapath.
//  - NUM_RD read ports and two write ports (WB lanes 0/1); entry 0 hard-wired to zero.
//  - Same-cycle write->read forwarding.
//  - Post-reset clear sequencer: zeroes every entry and holds rf_ready low until done.
//  - Optional busy scoreboard for hazard detection in ID.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_bypass.sv | 52 +++++
 rtl/regfile_mp.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared types and defaults for the multi-port register file (regfile_mp).
//   rf_state_e : sequencer states (CLEAR sweep, RUN)
//   RF_*_DEF   : default geometry of the register file
//   rf_aw()    : address width for a given depth
// ----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int RF_WIDTH_DEF  = 32;
    localparam int RF_DEPTH_DEF  = 32;
    localparam int RF_NUM_RD_DEF = 2;

    // Address width needed to index 'depth' entries.
    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// ----------------------------------------------------------------------------
// regfile_bypass
// One combinational read port of the register file with same-cycle
// write->read forwarding from the two write-back lanes.
// Ports:
//   en      : 1 = file is in RUN and not in reset; 0 forces rd=0, hit=0
//   ra      : read address
//   we0/wa0/wd0, we1/wa1/wd1 : qualified write lanes (already gated by RUN)
//   arr_rd  : array contents at ra
//   rd      : read data (entry 0 always reads 0)
//   hit     : 1 when rd was taken from a write lane this cycle
// ----------------------------------------------------------------------------
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEF,
    parameter int AW    = 5
) (
    input  logic             en,
    input  logic [AW-1:0]    ra,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic [WIDTH-1:0] arr_rd,
    output logic [WIDTH-1:0] rd,
    output logic             hit
);

    // Read mux: lane 1 has priority over lane 0 because it is the later
    // write in program order, matching the array write priority.
    always_comb begin
        rd  = '0;
        hit = 1'b0;
        if (!en || (ra == '0)) begin
            rd  = '0;
            hit = 1'b0;
        end else if (we1 && (wa1 == ra)) begin
            rd  = wd1;
            hit = 1'b1;
        end else if (we0 && (wa0 == ra)) begin
            rd  = wd0;
            hit = 1'b1;
        end else begin
            rd  = arr_rd;
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port integer register file for the pipelined datapath.
//   - NUM_RD combinational read ports, two write-back lanes (lane 1 wins on
//     an address collision), entry 0 hard-wired to zero.
//   - Same-cycle write->read forwarding on every read port.
//   - After reset a sequencer sweeps entries 1..DEPTH-1 to zero; rf_ready
//     stays low, and writes / issues are ignored, until the sweep completes.
//   - Optional busy scoreboard, enabled by defining RF_SCOREBOARD_EN.
//     Without it rbusy is tied low and iss_vld/iss_addr are unused.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ra  [NUM_RD*AW]   : read addresses, port i at [i*AW +: AW]
//   rd  [NUM_RD*WIDTH]: read data, port i at [i*WIDTH +: WIDTH]
//   we0/wa0/wd0       : write lane 0
//   we1/wa1/wd1       : write lane 1
//   rf_ready          : 1 = clear sweep done, file accepting writes
//   iss_vld/iss_addr  : scoreboard: instruction issued to iss_addr
//   rbusy [NUM_RD]    : scoreboard: read port i targets a pending write
// ----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH_DEF,
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int NUM_RD = RF_NUM_RD_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]   ra,
    output logic [NUM_RD*WIDTH-1:0]           rd,
    input  logic                              we0,
    input  logic [$clog2(DEPTH)-1:0]          wa0,
    input  logic [WIDTH-1:0]                  wd0,
    input  logic                              we1,
    input  logic [$clog2(DEPTH)-1:0]          wa1,
    input  logic [WIDTH-1:0]                  wd1,
    output logic                              rf_ready,
    input  logic                              iss_vld,
    input  logic [$clog2(DEPTH)-1:0]          iss_addr,
    output logic [NUM_RD-1:0]                 rbusy
);

    localparam int AW = rf_aw(DEPTH);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    rf_state_e        state_q,    state_d;
    logic [AW-1:0]    clr_idx_q,  clr_idx_d;
    logic             rf_ready_q, rf_ready_d;
    logic             clr_we_s;

    // Storage: no data reset, only the CLEAR sweep zeroes it.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Qualified write lanes and run indication shared by all ports.
    logic             run_s;
    logic             we0_s;
    logic             we1_s;
    logic [NUM_RD-1:0] hit_s;

    // rst is folded in so nothing is written, forwarded or issued on the
    // reset edge even when the FSM was in RUN.
    assign run_s = (state_q == RUN) && !rst;
    assign we0_s = we0 && run_s && (wa0 != '0);
    assign we1_s = we1 && run_s && (wa1 != '0);

    // State register: FSM state, sweep index and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_idx_q  <= AW'(1);
            rf_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rf_ready_q <= rf_ready_d;
        end
    end

    // Next-state logic: sweep 1..DEPTH-1, then enter RUN and stay there.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (rst) begin
            state_d   = CLEAR;
            clr_idx_d = AW'(1);
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_d = clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_d = RUN;
                    end else begin
                        state_d = CLEAR;
                    end
                end
                RUN: begin
                    state_d   = RUN;
                    clr_idx_d = clr_idx_q;
                end
                default: begin
                    state_d   = CLEAR;
                    clr_idx_d = AW'(1);
                end
            endcase
        end
    end

    // Output logic: ready is registered so it rises on the first RUN cycle.
    always_comb begin
        rf_ready_d = 1'b0;
        clr_we_s   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_s   = 1'b1;
                rf_ready_d = (state_d == RUN);
            end
            RUN: begin
                clr_we_s   = 1'b0;
                rf_ready_d = (state_d == RUN);
            end
            default: begin
                clr_we_s   = 1'b0;
                rf_ready_d = 1'b0;
            end
        endcase
    end

    assign rf_ready = rf_ready_q;

    // Array next value: sweep write in CLEAR, else lane 1 over lane 0.
    always_comb begin
        mem_d[0] = '0;
        for (int e = 1; e < DEPTH; e++) begin
            if (clr_we_s) begin
                if (clr_idx_q == AW'(e)) begin
                    mem_d[e] = '0;
                end else begin
                    mem_d[e] = mem_q[e];
                end
            end else if (we1_s && (wa1 == AW'(e))) begin
                mem_d[e] = wd1;
            end else if (we0_s && (wa0 == AW'(e))) begin
                mem_d[e] = wd0;
            end else begin
                mem_d[e] = mem_q[e];
            end
        end
    end

    // Array storage update.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= mem_d[e];
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_bypass #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_bypass (
            .en     (run_s),
            .ra     (ra[i*AW +: AW]),
            .we0    (we0_s),
            .wa0    (wa0),
            .wd0    (wd0),
            .we1    (we1_s),
            .wa1    (wa1),
            .wd1    (wd1),
            .arr_rd (mem_q[ra[i*AW +: AW]]),
            .rd     (rd[i*WIDTH +: WIDTH]),
            .hit    (hit_s[i])
        );
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [NUM_RD-1:0] rbusy_s;

    // Busy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Set on issue, clear on write-back; a same-cycle set beats the clear
    // because the issuing instruction is the newer producer.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int e = 1; e < DEPTH; e++) begin
            if (run_s && iss_vld && (iss_addr == AW'(e))) begin
                busy_d[e] = 1'b1;
            end else if ((we0_s && (wa0 == AW'(e))) ||
                         (we1_s && (wa1 == AW'(e)))) begin
                busy_d[e] = 1'b0;
            end else begin
                busy_d[e] = busy_q[e];
            end
        end
    end

    // A port that forwards this cycle already has its data, so it is not busy.
    always_comb begin
        rbusy_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (run_s && (ra[i*AW +: AW] != '0) && !hit_s[i]) begin
                rbusy_s[i] = busy_q[ra[i*AW +: AW]];
            end else begin
                rbusy_s[i] = 1'b0;
            end
        end
    end

    assign rbusy = rbusy_s;
`else
    logic sb_unused_s;

    assign sb_unused_s = ^{iss_vld, iss_addr, hit_s};
    assign rbusy       = '0;
`endif

endmodule
